// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake body controller:
//   - coordinate / length widths
//   - direction encoding (UP 00, DOWN 01, LEFT 10, RIGHT 11)
//   - game_status encodings driven by the game controller
//   - query_hit result encodings
//   - helper returning the direction opposite to a given one
// -----------------------------------------------------------------------------
package snake_pkg;

    localparam int X_W   = 6;   // grid column width
    localparam int Y_W   = 5;   // grid row width
    localparam int LEN_W = 5;   // body length width (holds 0..31)

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [1:0] GS_RESTART = 2'b00;
    localparam logic [1:0] GS_START   = 2'b01;
    localparam logic [1:0] GS_PLAY    = 2'b10;
    localparam logic [1:0] GS_DIE     = 2'b11;

    localparam logic [1:0] Q_EMPTY = 2'b00;
    localparam logic [1:0] Q_HEAD  = 2'b01;
    localparam logic [1:0] Q_BODY  = 2'b10;

    // A turn straight back into the neck is never allowed.
    function automatic dir_t opposite_dir(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_step_timer.sv
// -----------------------------------------------------------------------------
// snake_step_timer
// Free-running move timer. Counts clk cycles while enable is high and emits a
// one-cycle step pulse on the cycle whose count is STEP_CYCLES-1; the count
// then wraps to 0. When enable is low or clear is high the count is held at 0,
// so the first step after enable rises is exactly STEP_CYCLES cycles later.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   enable     count when high (game in PLAY and no collision)
//   clear      synchronous clear (restart)
//   step       one-cycle move pulse, decoded from the count register
// -----------------------------------------------------------------------------
module snake_step_timer #(
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic step
);

    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter: held at zero unless enabled, wraps after the step cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CNT_ZERO;
        end else if (clear || !enable) begin
            count_r <= CNT_ZERO;
        end else if (count_r == CNT_LAST) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_r + CNT_ONE;
        end
    end

    // The pulse must coincide with the wrap edge, so it is a decode of count_r.
    assign step = enable && !clear && (count_r == CNT_LAST);

endmodule

// File: rtl/snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl
// Snake position and motion engine. Latches a pending direction from the key
// pulses, moves the head one cell per step tick in PLAY, shifts the body
// segment array behind it, grows on food, and flags wall / self collisions.
// Also answers registered per-cell occupancy queries for the renderer.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   key1..key4_press         UP / DOWN / LEFT / RIGHT pulses (key1 highest prio)
//   game_status              00 RESTART, 01 START, 10 PLAY, 11 DIE
//   restart                  active-low synchronous reinitialise
//   grow                     food-eaten pulse
//   hit_wall, hit_body       sticky collision flags
//   head_x, head_y, body_len registered head position and length
//   query_x, query_y         renderer cell
//   query_hit                00 empty, 01 head, 10 body (one-cycle latency)
// -----------------------------------------------------------------------------
module snake_body_ctrl
    import snake_pkg::*;
#(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int MAX_LEN     = 16,
    parameter int INIT_LEN    = 3,
    parameter int STEP_CYCLES = 12_500_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key1_press,
    input  logic             key2_press,
    input  logic             key3_press,
    input  logic             key4_press,
    input  logic [1:0]       game_status,
    input  logic             restart,
    input  logic             grow,
    output logic             hit_wall,
    output logic             hit_body,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] body_len,
    input  logic [X_W-1:0]   query_x,
    input  logic [Y_W-1:0]   query_y,
    output logic [1:0]       query_hit
);

    localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   X_ZERO   = {X_W{1'b0}};
    localparam logic [Y_W-1:0]   Y_ZERO   = {Y_W{1'b0}};
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    logic [X_W-1:0]   seg_x_r [MAX_LEN];
    logic [Y_W-1:0]   seg_y_r [MAX_LEN];
    dir_t             dir_r;
    dir_t             pend_dir_r;
    logic [LEN_W-1:0] len_r;
    logic             grow_pending_r;
    logic             hit_wall_r;
    logic             hit_body_r;
    logic [1:0]       query_hit_r;

    logic             step_s;
    logic             timer_en_s;
    logic             key_valid_s;
    dir_t             key_dir_s;
    logic             key_accept_s;
    logic [X_W-1:0]   next_x_s;
    logic [Y_W-1:0]   next_y_s;
    logic             wall_s;
    logic [MAX_LEN-1:0] body_cmp_s;
    logic [MAX_LEN-1:0] body_q_s;
    logic             body_hit_s;
    logic             head_q_s;

    assign timer_en_s = (game_status == GS_PLAY) && !hit_wall_r && !hit_body_r;

    snake_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (timer_en_s),
        .clear  (!restart),
        .step   (step_s)
    );

    // Pick the highest-priority key this cycle; the opposite-direction filter
    // compares against the committed direction, not the pending one.
    always_comb begin
        key_valid_s = 1'b0;
        key_dir_s   = DIR_RIGHT;
        if (key1_press) begin
            key_valid_s = 1'b1;
            key_dir_s   = DIR_UP;
        end else if (key2_press) begin
            key_valid_s = 1'b1;
            key_dir_s   = DIR_DOWN;
        end else if (key3_press) begin
            key_valid_s = 1'b1;
            key_dir_s   = DIR_LEFT;
        end else if (key4_press) begin
            key_valid_s = 1'b1;
            key_dir_s   = DIR_RIGHT;
        end else begin
            key_valid_s = 1'b0;
            key_dir_s   = DIR_RIGHT;
        end
        key_accept_s = key_valid_s
                    && ((game_status == GS_START) || (game_status == GS_PLAY))
                    && (key_dir_s != opposite_dir(dir_r));
    end

    // Candidate next head cell in the pending direction, plus the wall test.
    always_comb begin
        next_x_s = seg_x_r[0];
        next_y_s = seg_y_r[0];
        wall_s   = 1'b0;
        case (pend_dir_r)
            DIR_UP: begin
                if (seg_y_r[0] == Y_ZERO) wall_s = 1'b1;
                else                      next_y_s = seg_y_r[0] - Y_ONE;
            end
            DIR_DOWN: begin
                if (seg_y_r[0] == Y_MAX) wall_s = 1'b1;
                else                     next_y_s = seg_y_r[0] + Y_ONE;
            end
            DIR_LEFT: begin
                if (seg_x_r[0] == X_ZERO) wall_s = 1'b1;
                else                      next_x_s = seg_x_r[0] - X_ONE;
            end
            DIR_RIGHT: begin
                if (seg_x_r[0] == X_MAX) wall_s = 1'b1;
                else                     next_x_s = seg_x_r[0] + X_ONE;
            end
            default: wall_s = 1'b0;
        endcase
    end

    assign body_cmp_s[0] = 1'b0;
    assign body_q_s[0]   = 1'b0;

    // Per-segment compares. The tail (index len-1) vacates its cell on a plain
    // move, so it only blocks the head when the snake is about to grow.
    for (genvar i = 1; i < MAX_LEN; i++) begin : g_seg_cmp
        assign body_cmp_s[i] = (seg_x_r[i] == next_x_s) && (seg_y_r[i] == next_y_s)
                            && (((LEN_W'(i) + LEN_W'(2)) <= len_r)
                                || (grow_pending_r && ((LEN_W'(i) + LEN_ONE) == len_r)));
        assign body_q_s[i]   = (seg_x_r[i] == query_x) && (seg_y_r[i] == query_y)
                            && (LEN_W'(i) < len_r);
    end

    assign body_hit_s = |body_cmp_s;
    assign head_q_s   = (seg_x_r[0] == query_x) && (seg_y_r[0] == query_y);

    // Game state: segments, direction, length, growth and collision flags.
    // restart low behaves exactly like the asynchronous reset, at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= X_W'(GRID_W / 2 - i);
                seg_y_r[i] <= Y_W'(GRID_H / 2);
            end
            dir_r          <= DIR_RIGHT;
            pend_dir_r     <= DIR_RIGHT;
            len_r          <= LEN_INIT;
            grow_pending_r <= 1'b0;
            hit_wall_r     <= 1'b0;
            hit_body_r     <= 1'b0;
        end else if (!restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= X_W'(GRID_W / 2 - i);
                seg_y_r[i] <= Y_W'(GRID_H / 2);
            end
            dir_r          <= DIR_RIGHT;
            pend_dir_r     <= DIR_RIGHT;
            len_r          <= LEN_INIT;
            grow_pending_r <= 1'b0;
            hit_wall_r     <= 1'b0;
            hit_body_r     <= 1'b0;
        end else begin
            if (step_s) begin
                dir_r <= pend_dir_r;
                if (wall_s) begin
                    hit_wall_r <= 1'b1;
                end else if (body_hit_s) begin
                    hit_body_r <= 1'b1;
                end else begin
                    for (int i = 1; i < MAX_LEN; i++) begin
                        seg_x_r[i] <= seg_x_r[i-1];
                        seg_y_r[i] <= seg_y_r[i-1];
                    end
                    seg_x_r[0] <= next_x_s;
                    seg_y_r[0] <= next_y_s;
                    if (grow_pending_r) begin
                        grow_pending_r <= 1'b0;
                        if (len_r < LEN_MAX) begin
                            len_r <= len_r + LEN_ONE;
                        end
                    end
                end
            end
            // A key on the step cycle lands in pend_dir after the commit above.
            if (key_accept_s) begin
                pend_dir_r <= key_dir_s;
            end
            // A fresh grow pulse wins over consumption in the same cycle.
            if (grow && (game_status == GS_PLAY)) begin
                grow_pending_r <= 1'b1;
            end
        end
    end

    // Registered renderer query against the current segment state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            query_hit_r <= Q_EMPTY;
        end else if (!restart) begin
            query_hit_r <= Q_EMPTY;
        end else if (head_q_s) begin
            query_hit_r <= Q_HEAD;
        end else if (|body_q_s) begin
            query_hit_r <= Q_BODY;
        end else begin
            query_hit_r <= Q_EMPTY;
        end
    end

    assign hit_wall  = hit_wall_r;
    assign hit_body  = hit_body_r;
    assign head_x    = seg_x_r[0];
    assign head_y    = seg_y_r[0];
    assign body_len  = len_r;
    assign query_hit = query_hit_r;

endmodule

// File: tb/tb_snake_body_ctrl.sv
module tb_snake_body_ctrl;

    localparam int K_HX   = 0;
    localparam int K_HY   = 1;
    localparam int K_LEN  = 2;
    localparam int K_WALL = 3;
    localparam int K_BODY = 4;
    localparam int K_QH   = 5;

    logic       clk;
    logic       rst;
    logic       key1_press, key2_press, key3_press, key4_press;
    logic [1:0] game_status;
    logic       restart;
    logic       grow;
    logic       hit_wall, hit_body;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] body_len;
    logic [5:0] query_x;
    logic [4:0] query_y;
    logic [1:0] query_hit;

    typedef struct {
        int    kind;
        int    exp_v;
        string name;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    snake_body_ctrl #(
        .GRID_W(40), .GRID_H(30), .MAX_LEN(16), .INIT_LEN(3), .STEP_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .key1_press(key1_press), .key2_press(key2_press),
        .key3_press(key3_press), .key4_press(key4_press),
        .game_status(game_status), .restart(restart), .grow(grow),
        .hit_wall(hit_wall), .hit_body(hit_body),
        .head_x(head_x), .head_y(head_y), .body_len(body_len),
        .query_x(query_x), .query_y(query_y), .query_hit(query_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: a run that never reaches the end is a failure.
    initial begin
        #200000;
        $display("FAIL timeout: test did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    function automatic int dut_val(input int kind);
        case (kind)
            K_HX:    return int'(head_x);
            K_HY:    return int'(head_y);
            K_LEN:   return int'(body_len);
            K_WALL:  return int'(hit_wall);
            K_BODY:  return int'(hit_body);
            K_QH:    return int'(query_hit);
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            int   act;
            e   = sb_q.pop_front();
            act = dut_val(e.kind);
            n_checks++;
            if (act != e.exp_v)
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp_v);
            else
                n_pass++;
        end
    end

    task automatic check_now(input int kind, input int exp_v, input string name);
        int act;
        act = dut_val(kind);
        n_checks++;
        if (act != exp_v)
            $display("FAIL %s: got %0d expected %0d (immediate)", name, act, exp_v);
        else
            n_pass++;
    endtask

    task automatic expect_val(input int kind, input int exp_v, input string name);
        sb_q.push_back('{kind, exp_v, name});
    endtask

    task automatic expect_head(input int x, input int y, input string name);
        expect_val(K_HX, x, {name, "_x"});
        expect_val(K_HY, y, {name, "_y"});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        game_status = 2'b00;
        restart = 1'b0;
        tick(1);
        restart = 1'b1;
    endtask

    task automatic do_query(input int x, input int y, input int exp_v, input string name);
        query_x = 6'(x);
        query_y = 5'(y);
        tick(1);
        expect_val(K_QH, exp_v, name);
    endtask

    initial begin
        rst = 1'b0; restart = 1'b1; grow = 1'b0; game_status = 2'b00;
        key1_press = 1'b0; key2_press = 1'b0; key3_press = 1'b0; key4_press = 1'b0;
        query_x = 6'd0; query_y = 5'd0;
        tick(2);
        rst = 1'b1;

        // Reset state and queries
        expect_head(20, 15, "rst_head");
        check_now(K_LEN, 3, "rst_len");
        check_now(K_WALL, 0, "rst_wall");
        check_now(K_BODY, 0, "rst_body");
        expect_val(K_QH, 0, "rst_query");
        do_query(18, 15, 2, "q_tail");
        do_query(20, 15, 1, "q_head");
        do_query(17, 15, 0, "q_beyond_len");
        do_query(16, 15, 0, "q_unused_seg");

        // Straight run to the right wall
        game_status = 2'b10;
        tick(3);
        expect_val(K_HX, 20, "pre_first_step");
        tick(1);
        expect_val(K_HX, 21, "first_step");
        for (int k = 2; k <= 19; k++) begin
            tick(4);
            expect_val(K_HX, 20 + k, "run_x");
        end
        tick(4);
        expect_val(K_WALL, 1, "wall_hit");
        expect_head(39, 15, "wall_head");
        tick(8);
        expect_val(K_HX, 39, "wall_frozen");
        do_restart();
        expect_head(20, 15, "rs1_head");
        expect_val(K_WALL, 0, "rs1_wall");
        expect_val(K_LEN, 3, "rs1_len");

        // Turns, ignored reversal, priority, key on the step cycle
        game_status = 2'b10;
        key1_press = 1'b1; tick(1); key1_press = 1'b0; tick(3);
        expect_head(20, 14, "turn_up");
        key3_press = 1'b1; tick(1); key3_press = 1'b0; tick(3);
        expect_head(19, 14, "turn_left");
        key4_press = 1'b1; tick(1); key4_press = 1'b0; tick(3);
        expect_head(18, 14, "reverse_ignored");
        key2_press = 1'b1; key3_press = 1'b1; tick(1);
        key2_press = 1'b0; key3_press = 1'b0; tick(3);
        expect_head(18, 15, "key_priority");
        tick(3);
        key3_press = 1'b1; tick(1); key3_press = 1'b0;
        expect_head(18, 16, "key_on_step");
        tick(4);
        expect_head(17, 16, "key_next_step");
        do_restart();

        // Growth up to saturation
        game_status = 2'b10;
        for (int k = 1; k <= 15; k++) begin
            grow = 1'b1; tick(1); grow = 1'b0; tick(3);
            expect_val(K_LEN, (3 + k > 16) ? 16 : 3 + k, "grow_len");
            expect_val(K_HX, 20 + k, "grow_x");
        end
        tick(4);
        expect_val(K_LEN, 16, "grow_sat_len");
        expect_val(K_HX, 36, "grow_sat_x");
        do_restart();

        // Self collision with a length-5 snake
        game_status = 2'b10;
        grow = 1'b1; tick(1); grow = 1'b0; tick(3);
        grow = 1'b1; tick(1); grow = 1'b0; tick(3);
        expect_head(22, 15, "len5_head");
        expect_val(K_LEN, 5, "len5_len");
        key1_press = 1'b1; tick(1); key1_press = 1'b0; tick(3);
        key3_press = 1'b1; tick(1); key3_press = 1'b0; tick(3);
        expect_head(21, 14, "coil_head");
        key2_press = 1'b1; tick(1); key2_press = 1'b0; tick(3);
        expect_val(K_BODY, 1, "body_hit");
        expect_val(K_WALL, 0, "body_hit_wall");
        expect_head(21, 14, "body_hit_head");
        do_query(22, 15, 2, "q_coil_body");
        tick(8);
        expect_head(21, 14, "body_frozen");
        query_x = 6'd21; query_y = 5'd14;
        do_restart();
        expect_val(K_QH, 0, "q_restart_override");
        expect_head(20, 15, "rs_head");
        expect_val(K_BODY, 0, "rs_body");
        expect_val(K_LEN, 3, "rs_len");
        do_query(19, 15, 2, "q_after_rs");

        // START latches keys but never moves; DIE freezes and ignores keys
        game_status = 2'b01;
        key2_press = 1'b1; tick(1); key2_press = 1'b0;
        key1_press = 1'b1; tick(1); key1_press = 1'b0;
        tick(100);
        expect_head(20, 15, "start_still");
        game_status = 2'b10;
        tick(4);
        expect_head(20, 14, "start_key_used");
        tick(2);
        game_status = 2'b11;
        key3_press = 1'b1; tick(1); key3_press = 1'b0;
        tick(20);
        expect_head(20, 14, "die_frozen");
        game_status = 2'b10;
        tick(3);
        expect_head(20, 14, "die_counter_cleared");
        tick(1);
        expect_head(20, 13, "die_key_ignored");

        tick(1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
